// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_port
// Purpose  : Operand-read port of the R0..R7/B0 register file. Each accepted
//            request selects operands A and B, forwarding same-cycle stores
//            from s_bus, and queues them in a 2-entry output buffer.
// Revision : 1.0
// ============================================================================
module reg_read_port #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            sel_a,
  input  logic [3:0]            sel_b,
  input  logic [NREG*WIDTH-1:0] r_flat,
  input  logic [WIDTH-1:0]      b0_q,
  input  logic [NREG-1:0]       SR,
  input  logic                  SB0,
  input  logic [WIDTH-1:0]      s_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      a_bus,
  output logic [WIDTH-1:0]      b_bus,
  output logic                  err_sel
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_a_q [2];
  logic [WIDTH-1:0] mem_a_d [2];
  logic [WIDTH-1:0] mem_b_q [2];
  logic [WIDTH-1:0] mem_b_d [2];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] regs_w [NREG];
  logic [WIDTH-1:0] op_a_w, op_b_w;
  logic             ill_a_w, ill_b_w;
  logic             push_w, pop_w;

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_unpack
      assign regs_w[g] = r_flat[g*WIDTH +: WIDTH];
    end
  endgenerate

  // A store landing on the selected register this cycle wins over the stale
  // register output, so the operand matches what the file will hold next.
  always_comb begin
    op_a_w  = '0;
    op_b_w  = '0;
    ill_a_w = 1'b1;
    ill_b_w = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (sel_a == 4'(i)) begin
        ill_a_w = 1'b0;
        op_a_w  = SR[i] ? s_bus : regs_w[i];
      end
      if (sel_b == 4'(i)) begin
        ill_b_w = 1'b0;
        op_b_w  = SR[i] ? s_bus : regs_w[i];
      end
    end
    if (sel_a == 4'(NREG)) begin
      ill_a_w = 1'b0;
      op_a_w  = SB0 ? s_bus : b0_q;
    end
    if (sel_b == 4'(NREG)) begin
      ill_b_w = 1'b0;
      op_b_w  = SB0 ? s_bus : b0_q;
    end
  end

  assign req_ready = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push_w    = req_valid && req_ready;
  assign pop_w     = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q | (push_w & (ill_a_w | ill_b_w));

    case (state_q)
      S_EMPTY: if (push_w) state_d = S_ONE;
      S_ONE: begin
        if (push_w && !pop_w)      state_d = S_FULL;
        else if (pop_w && !push_w) state_d = S_EMPTY;
      end
      S_FULL:  if (pop_w) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase

    if (push_w) begin
      mem_a_d[wr_ptr_q] = op_a_w;
      mem_b_d[wr_ptr_q] = op_b_w;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop_w) rd_ptr_d = ~rd_ptr_q;

    // Output registers track the next head; they keep the last head when empty.
    if (state_d != S_EMPTY) begin
      a_d = mem_a_d[rd_ptr_d];
      b_d = mem_b_d[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_a_q  <= '{default: '0};
      mem_b_q  <= '{default: '0};
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_a_q  <= mem_a_d;
      mem_b_q  <= mem_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

  assign a_bus   = a_q;
  assign b_bus   = b_q;
  assign err_sel = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_read_port
// Purpose  : Scoreboard bench for reg_read_port.
// Revision : 1.0
// ============================================================================
module tb_reg_read_port;

  localparam int c_W = 16;
  localparam int c_N = 8;

  logic               CLK = 1'b0;
  logic               CLR;
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         sel_a, sel_b;
  logic [c_N*c_W-1:0] r_flat;
  logic [c_W-1:0]     b0_q;
  logic [c_N-1:0]     SR;
  logic               SB0;
  logic [c_W-1:0]     s_bus;
  logic               out_valid;
  logic               out_ready;
  logic [c_W-1:0]     a_bus, b_bus;
  logic               err_sel;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = '0;
  logic        err_exp = 1'b0;

  reg_read_port #(.WIDTH(c_W), .NREG(c_N)) u_dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
    .sel_a(sel_a), .sel_b(sel_b), .r_flat(r_flat), .b0_q(b0_q), .SR(SR),
    .SB0(SB0), .s_bus(s_bus), .out_valid(out_valid), .out_ready(out_ready),
    .a_bus(a_bus), .b_bus(b_bus), .err_sel(err_sel)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_op(input logic [3:0] sel);
    if (sel < 4'd8) return {1'b0, SR[sel] ? s_bus : r_flat[sel*16 +: 16]};
    if (sel == 4'd8) return {1'b0, SB0 ? s_bus : b0_q};
    return {1'b1, 16'h0000};
  endfunction

  // One clock: check outputs mid-cycle, then advance the model over the edge.
  task automatic step();
    logic        push, pop;
    logic [16:0] ea, eb;
    @(negedge CLK);
    chk("req_ready", {31'd0, req_ready}, {31'd0, sb_q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
    chk("a_bus", {16'd0, a_bus}, {16'd0, last_exp[31:16]});
    chk("b_bus", {16'd0, b_bus}, {16'd0, last_exp[15:0]});
    chk("err_sel", {31'd0, err_sel}, {31'd0, err_exp});
    push = req_valid && (sb_q.size() < 2);
    pop  = (sb_q.size() > 0) && out_ready;
    ea   = ref_op(sel_a);
    eb   = ref_op(sel_b);
    @(posedge CLK);
    if (CLR) begin
      sb_q.delete();
      err_exp  = 1'b0;
      last_exp = '0;
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        sb_q.push_back({ea[15:0], eb[15:0]});
        err_exp = err_exp | ea[16] | eb[16];
      end
      if (sb_q.size() > 0) last_exp = sb_q[0];
    end
    #1;
  endtask

  task automatic set_reg(input int idx, input logic [15:0] v);
    r_flat[idx*16 +: 16] = v;
  endtask

  initial begin
    CLR = 1'b1; req_valid = 1'b0; sel_a = '0; sel_b = '0; r_flat = '0;
    b0_q = '0; SR = '0; SB0 = 1'b0; s_bus = '0; out_ready = 1'b0;
    for (int i = 0; i < c_N; i++) set_reg(i, 16'(16'h1000 + i * 16'h0111));
    step(); step();
    CLR = 1'b0;
    step(); step();

    // Plain register read with consumer ready
    set_reg(3, 16'h1234); set_reg(5, 16'hABCD);
    out_ready = 1'b1; req_valid = 1'b1; sel_a = 4'd3; sel_b = 4'd5;
    step();
    req_valid = 1'b0;
    step(); step();

    // Bypass on A, B0 without store on B, then B0 with store
    set_reg(2, 16'h0000); b0_q = 16'h0F0F;
    req_valid = 1'b1; sel_a = 4'd2; sel_b = 4'd8; SR = 8'h04; s_bus = 16'h5A5A; SB0 = 1'b0;
    step();
    SR = '0; sel_a = 4'd8; sel_b = 4'd8; SB0 = 1'b1; s_bus = 16'hC3C3;
    step();
    SB0 = 1'b0; req_valid = 1'b0;
    step(); step();

    // Back-pressure: three requests, only two fit; snapshots survive later writes
    out_ready = 1'b0; req_valid = 1'b1;
    sel_a = 4'd0; sel_b = 4'd1; step();
    sel_a = 4'd6; sel_b = 4'd7; step();
    set_reg(0, 16'hDEAD); set_reg(6, 16'hBEEF);
    sel_a = 4'd4; sel_b = 4'd4; step(); step();
    out_ready = 1'b1;
    step(); step();
    req_valid = 1'b0;
    step(); step(); step();

    // Illegal select is sticky
    req_valid = 1'b1; sel_a = 4'd12; sel_b = 4'd1;
    step();
    sel_a = 4'd3; sel_b = 4'd2;
    step(); step();
    req_valid = 1'b0;
    step(); step();

    // Reset while full with a request pending
    out_ready = 1'b0; req_valid = 1'b1; sel_a = 4'd15;
    step(); step(); step();
    CLR = 1'b1;
    step();
    CLR = 1'b0; req_valid = 1'b0;
    step(); step();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      sel_a     = 4'($urandom_range(0, 8));
      sel_b     = ($urandom_range(0, 40) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
      SR        = 8'($urandom);
      SB0       = 1'($urandom_range(0, 1));
      s_bus     = 16'($urandom);
      b0_q      = 16'($urandom);
      set_reg(int'($urandom_range(0, 7)), 16'($urandom));
      CLR       = ($urandom_range(0, 60) == 0);
      step();
    end
    CLR = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
